// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator host-side command path:
// instruction field layout, opcodes and transmitter FSM states.
package accel_pkg;

    localparam int OPC_MSB      = 63;
    localparam int OPC_LSB      = 60;
    localparam int BUF_ADDR_MSB = 46;
    localparam int BUF_ADDR_LSB = 32;
    localparam int OUT_ADDR_W   = 4;

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_LOAD_INP = 4'd1;
    localparam logic [3:0] OP_LOAD_WT  = 4'd2;
    localparam logic [3:0] OP_COMPUTE  = 4'd3;
    localparam logic [3:0] OP_READ_OUT = 4'd4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WAIT_RD = 2'd1;
    localparam state_t ST_RES     = 2'd2;

    function automatic logic op_issues(input logic [3:0] op);
        return (op >= OP_LOAD_INP) && (op <= OP_READ_OUT);
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_READ_OUT;
    endfunction

endpackage

// File: rtl/accel_cmd_tx_if.sv
// Host-facing streams of the command transmitter: instruction
// input stream and read-result output stream.
interface accel_cmd_tx_if;
    import accel_pkg::*;

    logic [63:0]           host_instr;
    logic                  host_valid;
    logic                  host_ready;
    logic [31:0]           res_data;
    logic [OUT_ADDR_W-1:0] res_addr;
    logic                  res_valid;
    logic                  res_ready;

    modport master (
        output host_instr, host_valid, res_ready,
        input  host_ready, res_data, res_addr, res_valid
    );

    modport slave (
        input  host_instr, host_valid, res_ready,
        output host_ready, res_data, res_addr, res_valid
    );

endinterface

// File: rtl/accel_cmd_tx.sv
// Drives host instructions onto the accelerator port one cycle after
// accept, and returns READ_OUT data after a fixed read latency.
module accel_cmd_tx
    import accel_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    accel_cmd_tx_if.slave    host,
    output logic [63:0]      accelerator_input,
    input  logic             buffer_full,
    input  logic [31:0]      accelerator_output,
    output logic [CNT_W-1:0] tx_count,
    output logic             err_opcode
);

    state_t                state;
    logic [3:0]            lat_cnt;
    logic [OUT_ADDR_W-1:0] rd_addr;
    logic [3:0]            opc;
    logic                  xfer;
    logic                  issue;

    assign opc   = host.host_instr[OPC_MSB:OPC_LSB];
    assign xfer  = host.host_valid && host.host_ready;
    assign issue = xfer && op_issues(opc);

    assign host.host_ready = (state == ST_IDLE) && !buffer_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            lat_cnt           <= '0;
            rd_addr           <= '0;
            accelerator_input <= '0;
            tx_count          <= '0;
            err_opcode        <= 1'b0;
            host.res_data     <= '0;
            host.res_addr     <= '0;
            host.res_valid    <= 1'b0;
        end else begin
            // Issued words live on the port for one cycle, NOP otherwise
            accelerator_input <= issue ? host.host_instr : '0;

            if (issue && (tx_count != '1))
                tx_count <= tx_count + 1'b1;

            if (xfer && op_illegal(opc))
                err_opcode <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (issue && (opc == OP_READ_OUT)) begin
                        rd_addr <= host.host_instr[OUT_ADDR_W-1:0];
                        lat_cnt <= 4'(RD_LAT);
                        state   <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (lat_cnt == 4'd0) begin
                        host.res_data  <= accelerator_output;
                        host.res_addr  <= rd_addr;
                        host.res_valid <= 1'b1;
                        state          <= ST_RES;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_RES: begin
                    if (host.res_valid && host.res_ready) begin
                        host.res_valid <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_cmd_tx.sv
// Bench for accel_cmd_tx: directed scenarios plus a randomized
// stream checked against a transaction-level reference model.
module tb_accel_cmd_tx;
    import accel_pkg::*;

    localparam int RD_LAT = 2;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             reset;
    logic [63:0]      accelerator_input;
    logic             buffer_full;
    logic [31:0]      accelerator_output;
    logic [CNT_W-1:0] tx_count;
    logic             err_opcode;

    int errors;
    int checks;

    logic [31:0] mem [16];
    logic        sr_v [RD_LAT];
    logic [3:0]  sr_a [RD_LAT];

    accel_cmd_tx_if hif ();

    accel_cmd_tx #(
        .RD_LAT(RD_LAT),
        .CNT_W (CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .host              (hif),
        .accelerator_input (accelerator_input),
        .buffer_full       (buffer_full),
        .accelerator_output(accelerator_output),
        .tx_count          (tx_count),
        .err_opcode        (err_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accelerator stand-in: read data valid exactly RD_LAT cycles after
    // READ_OUT is on accelerator_input, junk in every other cycle
    always @(posedge clk) begin
        sr_v[0] <= (accelerator_input[63:60] == OP_READ_OUT);
        sr_a[0] <= accelerator_input[3:0];
        for (int i = 1; i < RD_LAT; i++) begin
            sr_v[i] <= sr_v[i-1];
            sr_a[i] <= sr_a[i-1];
        end
    end

    assign accelerator_output =
        sr_v[RD_LAT-1] ? mem[sr_a[RD_LAT-1]] : 32'hBADBAD00;

    task automatic do_reset;
        reset           = 1'b1;
        hif.host_valid  = 1'b0;
        hif.host_instr  = '0;
        hif.res_ready   = 1'b0;
        buffer_full     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [63:0] w;
        w = 64'h4000_0000_0000_0003;
        do_reset;
        hif.host_valid = 1'b1;
        hif.host_instr = w;
        @(negedge clk);
        hif.host_valid = 1'b0;
        checks++;
        if (accelerator_input !== w) begin
            errors++;
            $display("FAIL rst_pre_acc got %h exp %h", accelerator_input, w);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (accelerator_input !== 64'h0) begin
            errors++;
            $display("FAIL rst_acc got %h exp 0", accelerator_input);
        end
        checks++;
        if (hif.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rv got %b exp 0", hif.res_valid);
        end
        checks++;
        if (tx_count !== '0) begin
            errors++;
            $display("FAIL rst_cnt got %h exp 0", tx_count);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (hif.host_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_rdy got %b exp 1", hif.host_ready);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (hif.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_abandon got %b exp 0", hif.res_valid);
        end
    endtask

    task automatic test_stream;
        logic [63:0] w1, w2;
        w1 = 64'h1000_0005_DEAD_BEEF;
        w2 = 64'h2000_0009_CAFE_F00D;
        do_reset;
        hif.host_valid = 1'b1;
        hif.host_instr = w1;
        #1;
        checks++;
        if (hif.host_ready !== 1'b1) begin
            errors++;
            $display("FAIL str_rdy got %b exp 1", hif.host_ready);
        end
        @(negedge clk);
        hif.host_instr = w2;
        checks++;
        if (accelerator_input !== w1) begin
            errors++;
            $display("FAIL str_w1 got %h exp %h", accelerator_input, w1);
        end
        @(negedge clk);
        hif.host_valid = 1'b0;
        checks++;
        if (accelerator_input !== w2) begin
            errors++;
            $display("FAIL str_w2 got %h exp %h", accelerator_input, w2);
        end
        @(negedge clk);
        checks++;
        if (accelerator_input !== 64'h0) begin
            errors++;
            $display("FAIL str_idle got %h exp 0", accelerator_input);
        end
        checks++;
        if (tx_count !== 4'd2) begin
            errors++;
            $display("FAIL str_cnt got %h exp 2", tx_count);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] w;
        w = 64'h3000_0000_0000_0042;
        buffer_full    = 1'b1;
        hif.host_valid = 1'b1;
        hif.host_instr = w;
        repeat (3) begin
            #1;
            checks++;
            if (hif.host_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_rdy got %b exp 0", hif.host_ready);
            end
            @(negedge clk);
            checks++;
            if (accelerator_input !== 64'h0) begin
                errors++;
                $display("FAIL bp_acc got %h exp 0", accelerator_input);
            end
        end
        buffer_full = 1'b0;
        #1;
        checks++;
        if (hif.host_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_rel_rdy got %b exp 1", hif.host_ready);
        end
        @(negedge clk);
        hif.host_valid = 1'b0;
        checks++;
        if (accelerator_input !== w) begin
            errors++;
            $display("FAIL bp_issue got %h exp %h", accelerator_input, w);
        end
        @(negedge clk);
        checks++;
        if (accelerator_input !== 64'h0) begin
            errors++;
            $display("FAIL bp_after got %h exp 0", accelerator_input);
        end
    endtask

    task automatic test_read;
        logic [63:0] w;
        w = 64'h4000_0000_0000_0007;
        mem[7] = 32'h1234_5678;
        hif.res_ready  = 1'b0;
        hif.host_valid = 1'b1;
        hif.host_instr = w;
        @(negedge clk);
        hif.host_valid = 1'b0;
        checks++;
        if (accelerator_input !== w) begin
            errors++;
            $display("FAIL rd_acc got %h exp %h", accelerator_input, w);
        end
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (hif.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL rd_early k=%0d got %b exp 0", k, hif.res_valid);
            end
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (hif.res_valid !== 1'b1 || hif.res_data !== 32'h1234_5678 ||
                hif.res_addr !== 4'h7 || hif.host_ready !== 1'b0) begin
                errors++;
                $display("FAIL rd_hold k=%0d got v=%b d=%h a=%h r=%b exp v=1 d=12345678 a=7 r=0",
                         k, hif.res_valid, hif.res_data, hif.res_addr, hif.host_ready);
            end
        end
        hif.res_ready = 1'b1;
        @(negedge clk);
        hif.res_ready = 1'b0;
        checks++;
        if (hif.res_valid !== 1'b0 || hif.host_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_done got v=%b r=%b exp v=0 r=1",
                     hif.res_valid, hif.host_ready);
        end
    endtask

    task automatic test_illegal;
        logic [63:0] wl;
        wl = 64'h1000_0001_0000_0055;
        do_reset;
        checks++;
        if (err_opcode !== 1'b0) begin
            errors++;
            $display("FAIL ill_init got %b exp 0", err_opcode);
        end
        hif.host_valid = 1'b1;
        hif.host_instr = 64'hA000_0001_1111_1111;
        @(negedge clk);
        hif.host_instr = 64'h0000_0000_0000_0099;
        checks++;
        if (accelerator_input !== 64'h0 || err_opcode !== 1'b1 || tx_count !== 4'd0) begin
            errors++;
            $display("FAIL ill_drop got acc=%h e=%b c=%h exp acc=0 e=1 c=0",
                     accelerator_input, err_opcode, tx_count);
        end
        @(negedge clk);
        hif.host_instr = wl;
        checks++;
        if (accelerator_input !== 64'h0 || tx_count !== 4'd0) begin
            errors++;
            $display("FAIL ill_nop got acc=%h c=%h exp acc=0 c=0",
                     accelerator_input, tx_count);
        end
        @(negedge clk);
        hif.host_valid = 1'b0;
        checks++;
        if (accelerator_input !== wl || err_opcode !== 1'b1 || tx_count !== 4'd1) begin
            errors++;
            $display("FAIL ill_sticky got acc=%h e=%b c=%h exp acc=%h e=1 c=1",
                     accelerator_input, err_opcode, tx_count, wl);
        end
    endtask

    task automatic test_saturate;
        logic [3:0] exp_c;
        do_reset;
        hif.host_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            hif.host_instr = {4'h3, 60'(i)};
            @(negedge clk);
            exp_c = (i < 15) ? 4'(i + 1) : 4'hF;
            checks++;
            if (tx_count !== exp_c) begin
                errors++;
                $display("FAIL sat i=%0d got %h exp %h", i, tx_count, exp_c);
            end
        end
        hif.host_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [63:0] m_acc;
        int          m_cnt;
        int          m_left;
        logic        m_err, m_busy, m_rv, rdy, x;
        logic [3:0]  m_addr, m_ra, op;
        logic [31:0] m_rd;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        do_reset;
        m_acc = '0; m_cnt = 0; m_left = 0;
        m_err = 0; m_busy = 0; m_rv = 0;
        m_addr = '0; m_ra = '0; m_rd = '0;
        for (int n = 0; n < 400; n++) begin
            hif.host_valid = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15))
                                             : 4'($urandom_range(0, 4));
            hif.host_instr = {op, 28'($urandom), 32'($urandom)};
            buffer_full    = ($urandom_range(0, 3) == 0);
            hif.res_ready  = 1'($urandom_range(0, 1));
            #1;
            rdy = !m_busy && !buffer_full;
            checks++;
            if (hif.host_ready !== rdy || accelerator_input !== m_acc ||
                hif.res_valid !== m_rv || tx_count !== 4'(m_cnt) ||
                err_opcode !== m_err) begin
                errors++;
                $display("FAIL rnd n=%0d got r=%b acc=%h v=%b c=%h e=%b exp r=%b acc=%h v=%b c=%h e=%b",
                         n, hif.host_ready, accelerator_input, hif.res_valid,
                         tx_count, err_opcode, rdy, m_acc, m_rv, 4'(m_cnt), m_err);
            end
            if (m_rv) begin
                checks++;
                if (hif.res_data !== m_rd || hif.res_addr !== m_ra) begin
                    errors++;
                    $display("FAIL rnd_res n=%0d got d=%h a=%h exp d=%h a=%h",
                             n, hif.res_data, hif.res_addr, m_rd, m_ra);
                end
            end
            x = hif.host_valid && rdy;
            m_acc = (x && op >= 1 && op <= 4) ? hif.host_instr : 64'h0;
            if (x && op >= 1 && op <= 4 && m_cnt < 15) m_cnt++;
            if (x && op > 4) m_err = 1'b1;
            if (m_rv && hif.res_ready) begin
                m_rv   = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy && m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_rv = 1'b1;
                    m_rd = mem[m_addr];
                    m_ra = m_addr;
                end
            end
            if (x && op == 4) begin
                m_busy = 1'b1;
                m_left = RD_LAT + 1;
                m_addr = hif.host_instr[3:0];
            end
            @(negedge clk);
        end
        hif.host_valid = 1'b0;
        buffer_full    = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset;
        test_stream;
        test_backpressure;
        test_read;
        test_illegal;
        test_saturate;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
